// File: rtl/input_pkg.sv
// Shared constants, coin FSM state type and per-player key decode for arcade_input_mapper.
package input_pkg;

  // Arrow keys match on the low 8 bits so extended and keypad codes both hit.
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DN = 8'h72;
  localparam logic [7:0] SC_LF = 8'h6B;
  localparam logic [7:0] SC_RT = 8'h74;

  localparam logic [8:0] SC_P0_FIRE_A  = 9'h029;
  localparam logic [8:0] SC_P0_FIRE_B  = 9'h014;
  localparam logic [8:0] SC_P0_START_A = 9'h016;
  localparam logic [8:0] SC_P0_START_B = 9'h005;
  localparam logic [8:0] SC_P0_COIN    = 9'h02E;
  localparam logic [8:0] SC_P1_UP      = 9'h02D;
  localparam logic [8:0] SC_P1_DN      = 9'h02B;
  localparam logic [8:0] SC_P1_LF      = 9'h023;
  localparam logic [8:0] SC_P1_RT      = 9'h034;
  localparam logic [8:0] SC_P1_FIRE    = 9'h01C;
  localparam logic [8:0] SC_P1_START_A = 9'h01E;
  localparam logic [8:0] SC_P1_START_B = 9'h006;
  localparam logic [8:0] SC_P1_COIN    = 9'h036;
  localparam logic [8:0] SC_P2_START   = 9'h026;
  localparam logic [8:0] SC_P2_COIN    = 9'h03D;
  localparam logic [8:0] SC_P3_START   = 9'h025;
  localparam logic [8:0] SC_P3_COIN    = 9'h03E;
  localparam logic [8:0] SC_CHEAT      = 9'h003;

  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_DOWN  = 2;
  localparam int JB_UP    = 3;
  localparam int JB_FIRE  = 4;
  localparam int JB_START = 5;
  localparam int JB_COIN  = 6;
  localparam int JB_AUTO  = 7;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  typedef struct packed {
    logic up;
    logic dn;
    logic lf;
    logic rt;
    logic fire;
    logic start;
    logic coin;
  } keyset_t;

  // One-hot-ish map of which key registers of player p a scan code addresses.
  function automatic keyset_t key_decode(input int p, input logic [8:0] sc);
    keyset_t k;
    k = '0;
    case (p)
      0: begin
        k.up    = (sc[7:0] == SC_UP);
        k.dn    = (sc[7:0] == SC_DN);
        k.lf    = (sc[7:0] == SC_LF);
        k.rt    = (sc[7:0] == SC_RT);
        k.fire  = (sc == SC_P0_FIRE_A) || (sc == SC_P0_FIRE_B);
        k.start = (sc == SC_P0_START_A) || (sc == SC_P0_START_B);
        k.coin  = (sc == SC_P0_COIN);
      end
      1: begin
        k.up    = (sc == SC_P1_UP);
        k.dn    = (sc == SC_P1_DN);
        k.lf    = (sc == SC_P1_LF);
        k.rt    = (sc == SC_P1_RT);
        k.fire  = (sc == SC_P1_FIRE);
        k.start = (sc == SC_P1_START_A) || (sc == SC_P1_START_B);
        k.coin  = (sc == SC_P1_COIN);
      end
      2: begin
        k.start = (sc == SC_P2_START);
        k.coin  = (sc == SC_P2_COIN);
      end
      3: begin
        k.start = (sc == SC_P3_START);
        k.coin  = (sc == SC_P3_COIN);
      end
      default: ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/input_coin_chan.sv
// One coin channel: fixed-length pulse, guard gap, and a single pending request slot.
import input_pkg::*;

module input_coin_chan #(
  parameter int COIN_PULSE = 1200000,
  parameter int COIN_GAP   = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  output logic o_coin
);

  localparam int CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  coin_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_req_d;
  logic          r_coin;
  logic          w_rise;
  logic          w_zero;

  assign w_rise = i_req & ~r_req_d;
  assign w_zero = (r_cnt == '0);
  assign o_coin = r_coin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_req_d <= 1'b0;
      r_coin  <= 1'b0;
    end else begin
      r_req_d <= i_req;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PULSE;
            r_cnt   <= CW'(COIN_PULSE - 1);
            r_coin  <= 1'b1;
          end
        end
        PULSE: begin
          if (w_rise) r_pend <= 1'b1;
          if (w_zero) begin
            r_state <= GAP;
            r_cnt   <= CW'(COIN_GAP - 1);
            r_coin  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          // An edge landing on the last gap cycle starts the next pulse directly.
          if (w_zero) begin
            if (r_pend || w_rise) begin
              r_state <= PULSE;
              r_cnt   <= CW'(COIN_PULSE - 1);
              r_coin  <= 1'b1;
              r_pend  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (w_rise) r_pend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player input front end: PS/2 key decode, joystick merge/rotate, coin channels.
// Optional autofire square wave is enabled with `define INPUT_AUTOFIRE_EN.
import input_pkg::*;

module arcade_input_mapper #(
  parameter int PLAYERS         = 2,
  parameter int COIN_PULSE      = 1200000,
  parameter int COIN_GAP        = 1200000,
  parameter int AUTOFIRE_PERIOD = 600000
) (
  input  logic                   clk_sys,
  input  logic                   RESET_N,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joystick,
  input  logic                   rotate,
  input  logic                   coin_on_start,
  output logic [4*PLAYERS-1:0]   dir,
  output logic [PLAYERS-1:0]     fire,
  output logic [PLAYERS-1:0]     start,
  output logic [PLAYERS-1:0]     coin,
  output logic                   cheat
);

`ifdef INPUT_AUTOFIRE_EN
  localparam int JW = 8;
  localparam int AW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;

  logic [AW-1:0] r_af_cnt;
  logic          r_af_sq;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_af_cnt <= '0;
      r_af_sq  <= 1'b1;
    end else if (r_af_cnt == AW'(AUTOFIRE_PERIOD - 1)) begin
      r_af_cnt <= '0;
      r_af_sq  <= ~r_af_sq;
    end else begin
      r_af_cnt <= r_af_cnt + 1'b1;
    end
  end
`else
  localparam int JW = 7;
  logic w_unused_cfg;
  assign w_unused_cfg = (AUTOFIRE_PERIOD > 0);
`endif

  logic r_primed;
  logic r_tog;
  logic r_cheat_key;
  logic r_cheat;
  logic w_evt;

  // The prime cycle only captures the toggle so a high level at reset release is not an event.
  assign w_evt = r_primed & (ps2_key[10] ^ r_tog);
  assign cheat = r_cheat;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_primed    <= 1'b0;
      r_tog       <= 1'b0;
      r_cheat_key <= 1'b0;
      r_cheat     <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      r_tog    <= ps2_key[10];
      if (w_evt && (ps2_key[8:0] == SC_CHEAT)) r_cheat_key <= ps2_key[9];
      r_cheat <= r_cheat_key;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    keyset_t         w_hit;
    keyset_t         w_raw;
    keyset_t         r_keys;
    logic [15:0]     w_joy;
    logic [JW-1:0]   r_joy;
    logic [3:0]      w_dir;
    logic [3:0]      r_dir;
    logic            w_fire;
    logic            r_fire;
    logic            r_start;
    logic            w_req;
    logic            w_unused_joy;

    assign w_hit        = key_decode(p, ps2_key[8:0]);
    assign w_joy        = joystick[16*p +: 16];
    assign w_unused_joy = ^w_joy[15:JW];

    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        r_keys <= '0;
        r_joy  <= '0;
      end else begin
        if (w_evt) r_keys <= (r_keys & ~w_hit) | (w_hit & {7{ps2_key[9]}});
        r_joy <= w_joy[JW-1:0];
      end
    end

    assign w_raw = r_keys | {r_joy[JB_UP], r_joy[JB_DOWN], r_joy[JB_LEFT], r_joy[JB_RIGHT],
                             r_joy[JB_FIRE], r_joy[JB_START], r_joy[JB_COIN]};
    // Rotated cabinet: up<-left, down<-right, left<-down, right<-up.
    assign w_dir = rotate ? {w_raw.lf, w_raw.rt, w_raw.dn, w_raw.up}
                          : {w_raw.up, w_raw.dn, w_raw.lf, w_raw.rt};
`ifdef INPUT_AUTOFIRE_EN
    assign w_fire = w_raw.fire | (r_joy[JB_AUTO] & r_af_sq);
`else
    assign w_fire = w_raw.fire;
`endif
    assign w_req = w_raw.coin | (coin_on_start & w_raw.start);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        r_dir   <= '0;
        r_fire  <= 1'b0;
        r_start <= 1'b0;
      end else begin
        r_dir   <= w_dir;
        r_fire  <= w_fire;
        r_start <= w_raw.start;
      end
    end

    assign dir[4*p +: 4] = r_dir;
    assign fire[p]       = r_fire;
    assign start[p]      = r_start;

    input_coin_chan #(
      .COIN_PULSE (COIN_PULSE),
      .COIN_GAP   (COIN_GAP)
    ) u_coin (
      .clk    (clk_sys),
      .rst_n  (RESET_N),
      .i_req  (w_req),
      .o_coin (coin[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (PLAYERS=2, COIN_PULSE=4, COIN_GAP=3, AUTOFIRE_PERIOD=5).
module tb_arcade_input_mapper;

  logic        clk_sys;
  logic        RESET_N;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic        rotate;
  logic        coin_on_start;
  logic [7:0]  dir;
  logic [1:0]  fire;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        cheat;

  int n_vec = 0;
  int n_err = 0;

  arcade_input_mapper #(
    .PLAYERS         (2),
    .COIN_PULSE      (4),
    .COIN_GAP        (3),
    .AUTOFIRE_PERIOD (5)
  ) dut (
    .clk_sys       (clk_sys),
    .RESET_N       (RESET_N),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .rotate        (rotate),
    .coin_on_start (coin_on_start),
    .dir           (dir),
    .fire          (fire),
    .start         (start),
    .coin          (coin),
    .cheat         (cheat)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic [8:0] sc, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, sc};
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    RESET_N = 1'b0; ps2_key = '0; joystick = '0; rotate = 1'b0; coin_on_start = 1'b0;
    repeat (3) step();
    outs = {dir, fire, start, coin, cheat};
    n_vec++;
    if (outs !== 15'h0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
    RESET_N = 1'b1;
    step();
    step();
    outs = {dir, fire, start, coin, cheat};
    n_vec++;
    if (outs !== 15'h0) begin n_err++; $display("FAIL post_reset_idle: got %h want 0", outs); end
  endtask

  task automatic test_dir();
    send_key(9'h175, 1'b1);
    step();
    n_vec++;
    if (dir !== 8'h00) begin n_err++; $display("FAIL dir_latency1: got %h want 00", dir); end
    step();
    n_vec++;
    if (dir !== 8'h08) begin n_err++; $display("FAIL dir_up_press: got %h want 08", dir); end
    send_key(9'h175, 1'b0);
    step(); step();
    n_vec++;
    if (dir !== 8'h00) begin n_err++; $display("FAIL dir_up_release: got %h want 00", dir); end
    send_key(9'h072, 1'b1);
    step(); step();
    n_vec++;
    if (dir !== 8'h04) begin n_err++; $display("FAIL dir_down_nonext: got %h want 04", dir); end
    send_key(9'h072, 1'b0);
    step();
    send_key(9'h034, 1'b1);
    step(); step();
    n_vec++;
    if (dir !== 8'h10) begin n_err++; $display("FAIL dir_p1_right: got %h want 10", dir); end
    send_key(9'h034, 1'b0);
    step(); step();
    n_vec++;
    if (dir !== 8'h00) begin n_err++; $display("FAIL dir_p1_release: got %h want 00", dir); end
  endtask

  task automatic test_back_to_back();
    send_key(9'h029, 1'b1);
    step();
    send_key(9'h029, 1'b0);
    step();
    n_vec++;
    if (fire !== 2'b01) begin n_err++; $display("FAIL b2b_press: got %b want 01", fire); end
    step();
    n_vec++;
    if (fire !== 2'b00) begin n_err++; $display("FAIL b2b_release: got %b want 00", fire); end
    send_key(9'h11C, 1'b1);
    step(); step();
    n_vec++;
    if (fire !== 2'b00) begin n_err++; $display("FAIL unlisted_code: got %b want 00", fire); end
    send_key(9'h11C, 1'b0);
    step();
    send_key(9'h003, 1'b1);
    step(); step();
    n_vec++;
    if (cheat !== 1'b1) begin n_err++; $display("FAIL cheat_press: got %b want 1", cheat); end
    send_key(9'h003, 1'b0);
    step(); step();
    n_vec++;
    if (cheat !== 1'b0) begin n_err++; $display("FAIL cheat_release: got %b want 0", cheat); end
  endtask

  task automatic test_rotate();
    rotate = 1'b1;
    joystick = 32'h0000_0002;
    step(); step();
    n_vec++;
    if (dir[3:0] !== 4'b1000) begin n_err++; $display("FAIL rot_left_to_up: got %b want 1000", dir[3:0]); end
    joystick = 32'h0000_0008;
    step(); step();
    n_vec++;
    if (dir[3:0] !== 4'b0001) begin n_err++; $display("FAIL rot_up_to_right: got %b want 0001", dir[3:0]); end
    joystick = 32'h0000_0004;
    step(); step();
    n_vec++;
    if (dir[3:0] !== 4'b0010) begin n_err++; $display("FAIL rot_down_to_left: got %b want 0010", dir[3:0]); end
    rotate = 1'b0;
    step(); step();
    n_vec++;
    if (dir[3:0] !== 4'b0100) begin n_err++; $display("FAIL norot_down: got %b want 0100", dir[3:0]); end
    joystick = '0;
    step(); step();
  endtask

  task automatic test_coin_key();
    logic [13:0] exp_c;
    exp_c = 14'b00000000011110;
    send_key(9'h02E, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step();
      n_vec++;
      if (coin !== {1'b0, exp_c[i]}) begin
        n_err++; $display("FAIL coin_key cyc%0d: got %b want %b", i, coin, {1'b0, exp_c[i]});
      end
    end
    send_key(9'h02E, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_coin_pend();
    logic [17:0] stim;
    logic [17:0] exp_c;
    stim  = 18'b000000000000100101;
    exp_c = 18'b000000111100011110;
    for (int i = 0; i < 18; i++) begin
      joystick[6] = stim[i];
      step();
      n_vec++;
      if (coin !== {1'b0, exp_c[i]}) begin
        n_err++; $display("FAIL coin_pend cyc%0d: got %b want %b", i, coin, {1'b0, exp_c[i]});
      end
    end
    joystick = '0;
  endtask

  task automatic test_coin_on_start();
    logic [14:0] outs;
    coin_on_start = 1'b1;
    send_key(9'h01E, 1'b1);
    step(); step();
    n_vec++;
    if (start !== 2'b10) begin n_err++; $display("FAIL cos_start: got %b want 10", start); end
    n_vec++;
    if (coin !== 2'b10) begin n_err++; $display("FAIL cos_coin: got %b want 10", coin); end
    step();
    #2;
    RESET_N = 1'b0;
    #1;
    n_vec++;
    if (coin !== 2'b00) begin n_err++; $display("FAIL async_reset_coin: got %b want 00", coin); end
    outs = {dir, fire, start, coin, cheat};
    n_vec++;
    if (outs !== 15'h0) begin n_err++; $display("FAIL async_reset_outs: got %h want 0", outs); end
    // Toggle held high with coin code across release: prime cycle must swallow it.
    ps2_key = {1'b1, 1'b1, 9'h02E};
    step(); step();
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if ({coin, start} !== 4'b0000) begin
        n_err++; $display("FAIL post_reset_quiet cyc%0d: got %b want 0000", i, {coin, start});
      end
    end
    coin_on_start = 1'b0;
    send_key(9'h02E, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_autofire();
    joystick[7] = 1'b1;
    step(); step();
`ifdef INPUT_AUTOFIRE_EN
    begin
      logic prev;
      int   run;
      int   edges;
      prev = fire[0]; run = 0; edges = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (fire[0] !== prev) begin
          if (edges > 0) begin
            n_vec++;
            if (run != 5) begin n_err++; $display("FAIL autofire_period: got %0d want 5", run); end
          end
          edges++; run = 1; prev = fire[0];
        end else begin
          run++;
        end
      end
      n_vec++;
      if (edges < 4) begin n_err++; $display("FAIL autofire_edges: got %0d want >=4", edges); end
    end
`else
    for (int i = 0; i < 12; i++) begin
      step();
      n_vec++;
      if (fire !== 2'b00) begin n_err++; $display("FAIL autofire_ignored cyc%0d: got %b want 00", i, fire); end
    end
`endif
    joystick = '0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_dir();
    test_back_to_back();
    test_rotate();
    test_coin_key();
    test_coin_pend();
    test_coin_on_start();
    test_autofire();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
